hack_cpu_core: RTL

- Hack-style CPU datapath/control stage directly upstream of the 16-bit ALU.
- Decodes each 16-bit instruction and holds the A, D and PC registers.
- Drives the ALU operands (x, y) and the six control bits (zx, nx, zy, ny, f, no).
- Consumes the ALU result and zero flag for register writeback, memory write and jump resolution.
- Instantiates the existing ALU module internally; one instruction retires per enabled clock.

---
 rtl/hack_cpu_core.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hack_cpu_core.sv
// Hack CPU datapath/control: A, D and PC registers around a 16-bit Hack ALU.
// Define HACK_CPU_RETIRE_CNT_EN to add the retired/jumped event counters.

module hack_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o,
    output logic        zr_o
);
    logic [15:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z   = zx_i ? 16'h0000 : x_i;
        x_n   = nx_i ? ~x_z : x_z;
        y_z   = zy_i ? 16'h0000 : y_i;
        y_n   = ny_i ? ~y_z : y_z;
        res   = f_i ? (x_n + y_n) : (x_n & y_n);
        out_o = no_i ? ~res : res;
        zr_o  = (out_o == 16'h0000);
    end
endmodule

module hack_cpu_core #(
    parameter int unsigned PC_W = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [15:0]     inst,
    input  logic [15:0]     in_m,
    output logic [15:0]     out_m,
    output logic            write_m,
    output logic [PC_W-1:0] address_m,
`ifdef HACK_CPU_RETIRE_CNT_EN
    output logic [31:0]     retired,
    output logic [31:0]     jumped,
`endif
    output logic [PC_W-1:0] pc
);
    logic [15:0]     a_q, a_d;
    logic [15:0]     d_q, d_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic        is_c;
    logic        sel_m, dst_a, dst_d, dst_m;
    logic        jlt, jeq, jgt;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        neg, pos, taken;
    logic [1:0]  unused_inst;

    // inst[14:13] carry no meaning in a C-instruction.
    assign unused_inst = inst[14:13];

    assign is_c  = inst[15];
    assign sel_m = inst[12];
    assign dst_a = inst[5];
    assign dst_d = inst[4];
    assign dst_m = inst[3];
    assign jlt   = inst[2];
    assign jeq   = inst[1];
    assign jgt   = inst[0];

    assign alu_y = sel_m ? in_m : a_q;

    hack_alu u_alu (
        .x_i   (d_q),
        .y_i   (alu_y),
        .zx_i  (inst[11]),
        .nx_i  (inst[10]),
        .zy_i  (inst[9]),
        .ny_i  (inst[8]),
        .f_i   (inst[7]),
        .no_i  (inst[6]),
        .out_o (alu_out),
        .zr_o  (alu_zr)
    );

    assign out_m     = alu_out;
    assign neg       = alu_out[15];
    assign pos       = ~neg & ~alu_zr;
    assign taken     = is_c & ((jlt & neg) | (jeq & alu_zr) | (jgt & pos));
    assign write_m   = ~rst & en & is_c & dst_m;
    assign address_m = a_q[PC_W-1:0];
    assign pc        = pc_q;

    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        // Jump target is the pre-edge A even when this instruction also writes A.
        pc_d = taken ? a_q[PC_W-1:0] : pc_q + 1'b1;
        if (!is_c) begin
            a_d = {1'b0, inst[14:0]};
        end else begin
            if (dst_a) a_d = alu_out;
            if (dst_d) d_d = alu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            pc_q <= '0;
        end else if (en) begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

`ifdef HACK_CPU_RETIRE_CNT_EN
    logic [31:0] retired_q, jumped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 32'd0;
            jumped_q  <= 32'd0;
        end else if (en) begin
            retired_q <= retired_q + 32'd1;
            if (taken) jumped_q <= jumped_q + 32'd1;
        end
    end

    assign retired = retired_q;
    assign jumped  = jumped_q;
`endif
endmodule
